// File: rtl/c2_serial.sv
// c2_serial: bit-serial two's-complement negate / absolute value, LSB first, one bit per clock.
// Define C2_SAT_EN to saturate overflowing results to the maximum positive value.
module c2_serial #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH:0]   r,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_sign;
    logic             r_mode;
    logic [WIDTH:0]   r_result;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic             w_bit;
    logic             w_invert;
    logic             w_out;
    logic             w_carryNext;
    logic [WIDTH-1:0] w_accNext;
    logic             w_ovf;

    // Abs of a non-negative operand passes bits through; everything else is ~x + 1.
    assign w_bit       = r_shift[0];
    assign w_invert    = ~r_mode | r_sign;
    assign w_out       = w_invert ? (~w_bit ^ r_carry) : w_bit;
    assign w_carryNext = ~w_bit & r_carry;
    assign w_accNext   = {w_out, r_acc[WIDTH-1:1]};

    // Only the minimum signed value maps onto itself, in either mode.
    assign w_ovf = (w_accNext == {1'b1, {(WIDTH-1){1'b0}}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_sign   <= 1'b0;
            r_mode   <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shift <= x;
                        r_sign  <= x[WIDTH-1];
                        r_mode  <= mode;
                        r_carry <= 1'b1;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_shift <= r_shift >> 1;
                    r_acc   <= w_accNext;
                    r_carry <= w_carryNext;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
`ifdef C2_SAT_EN
                        if (w_ovf)
                            r_result <= {2'b00, {(WIDTH-1){1'b1}}};
                        else
                            r_result <= {w_carryNext & ~r_mode, w_accNext};
`else
                        r_result <= {w_carryNext & ~r_mode, w_accNext};
`endif
                        r_ovf   <= w_ovf;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign r    = r_result;
    assign ovf  = r_ovf;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_c2_serial.sv
// Directed self-checking bench for c2_serial: a WIDTH=6 and a WIDTH=8 instance
// with hand-computed expected results (honours C2_SAT_EN when defined).
module tb_c2_serial;
    logic       clk = 1'b0;
    logic       rst_n;

    logic       start6, mode6, ovf6, busy6, done6;
    logic [5:0] x6;
    logic [6:0] r6;

    logic       start8, mode8, ovf8, busy8, done8;
    logic [7:0] x8;
    logic [8:0] r8;

    int vecCount  = 0;
    int missCount = 0;

`ifdef C2_SAT_EN
    localparam logic [6:0] EXP_MIN6 = 7'b0011111;
    localparam logic [8:0] EXP_MIN8 = 9'b0_0111_1111;
`else
    localparam logic [6:0] EXP_MIN6 = 7'b0100000;
    localparam logic [8:0] EXP_MIN8 = 9'b0_1000_0000;
`endif

    always #5 clk = ~clk;

    c2_serial #(.WIDTH(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .mode(mode6), .x(x6),
        .r(r6), .ovf(ovf6), .busy(busy6), .done(done6)
    );

    c2_serial #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .x(x8),
        .r(r8), .ovf(ovf8), .busy(busy8), .done(done8)
    );

    // Waits on negedges for done; cycles = negedges after the start edge (0-based), -1 on timeout.
    task automatic waitDone(input bit use8, output int cycles, output int busyCnt);
        cycles  = -1;
        busyCnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (use8 ? done8 : done6) begin
                cycles = i;
                return;
            end
            if (use8 ? busy8 : busy6) busyCnt++;
        end
        vecCount++;
        missCount++;
        $display("[TB] FAIL done_timeout: no done within 40 cycles (use8=%0d)", use8);
    endtask

    // Issues one start pulse and returns in the negedge where done is high.
    task automatic applyStimulus(input bit use8, input logic m, input logic [7:0] xv,
                                 output int cycles, output int busyCnt);
        @(negedge clk);
        if (use8) begin
            start8 = 1'b1; mode8 = m; x8 = xv;
        end else begin
            start6 = 1'b1; mode6 = m; x6 = xv[5:0];
        end
        @(posedge clk);
        #1;
        start6 = 1'b0;
        start8 = 1'b0;
        waitDone(use8, cycles, busyCnt);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start6 = 1'b0; mode6 = 1'b0; x6 = '0;
        start8 = 1'b0; mode8 = 1'b0; x8 = '0;
        #12;
        vecCount++;
        if ({r6, ovf6, busy6, done6} !== 10'b0) begin
            missCount++;
            $display("[TB] FAIL reset6: got r=%b ovf=%b busy=%b done=%b, want all 0", r6, ovf6, busy6, done6);
        end
        vecCount++;
        if ({r8, ovf8, busy8, done8} !== 12'b0) begin
            missCount++;
            $display("[TB] FAIL reset8: got r=%b ovf=%b busy=%b done=%b, want all 0", r8, ovf8, busy8, done8);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_negate();
        int cyc, bcnt;
        applyStimulus(1'b0, 1'b0, 8'b00_001100, cyc, bcnt);
        vecCount++;
        if (cyc !== 6 || bcnt !== 6) begin
            missCount++;
            $display("[TB] FAIL neg_latency: got done at %0d busy %0d cycles, want 6/6", cyc, bcnt);
        end
        vecCount++;
        if (r6 !== 7'b0110100 || ovf6 !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL neg_001100: got r=%b ovf=%b, want 0110100 0", r6, ovf6);
        end
        @(negedge clk);
        vecCount++;
        if (done6 !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL done_pulse: got done=%b one cycle later, want 0", done6);
        end

        applyStimulus(1'b0, 1'b0, 8'b00_000000, cyc, bcnt);
        vecCount++;
        if (r6 !== 7'b1000000 || ovf6 !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL neg_zero: got r=%b ovf=%b, want 1000000 0", r6, ovf6);
        end

        applyStimulus(1'b0, 1'b0, 8'b00_100000, cyc, bcnt);
        vecCount++;
        if (r6 !== EXP_MIN6 || ovf6 !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL neg_min: got r=%b ovf=%b, want %b 1", r6, ovf6, EXP_MIN6);
        end
    endtask

    task automatic test_abs();
        int cyc, bcnt;
        applyStimulus(1'b0, 1'b1, 8'b00_110110, cyc, bcnt);
        vecCount++;
        if (r6 !== 7'b0001010 || ovf6 !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL abs_neg: got r=%b ovf=%b, want 0001010 0", r6, ovf6);
        end
        applyStimulus(1'b0, 1'b1, 8'b00_100000, cyc, bcnt);
        vecCount++;
        if (r6 !== EXP_MIN6 || ovf6 !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL abs_min: got r=%b ovf=%b, want %b 1", r6, ovf6, EXP_MIN6);
        end
        applyStimulus(1'b0, 1'b1, 8'b00_010011, cyc, bcnt);
        vecCount++;
        if (r6 !== 7'b0010011 || ovf6 !== 1'b0 || cyc !== 6) begin
            missCount++;
            $display("[TB] FAIL abs_pos: got r=%b ovf=%b cyc=%0d, want 0010011 0 6", r6, ovf6, cyc);
        end
    endtask

    task automatic test_ignore_start();
        int cyc, bcnt, extra;
        @(negedge clk);
        start6 = 1'b1; mode6 = 1'b0; x6 = 6'b001100;
        @(posedge clk);
        #1 start6 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vecCount++;
        if (r6 !== 7'b0010011 || ovf6 !== 1'b0 || busy6 !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL hold_in_run: got r=%b ovf=%b busy=%b, want 0010011 0 1", r6, ovf6, busy6);
        end
        start6 = 1'b1; mode6 = 1'b1; x6 = 6'b000001;
        @(posedge clk);
        #1 start6 = 1'b0;
        waitDone(1'b0, cyc, bcnt);
        vecCount++;
        if (cyc !== 4 || r6 !== 7'b0110100 || ovf6 !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL ignore_start: got cyc=%0d r=%b ovf=%b, want 4 0110100 0", cyc, r6, ovf6);
        end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done6 || busy6) extra++;
        end
        vecCount++;
        if (extra !== 0) begin
            missCount++;
            $display("[TB] FAIL no_queue: got %0d busy/done cycles after finish, want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bcnt;
        applyStimulus(1'b0, 1'b1, 8'b00_110110, cyc, bcnt);
        vecCount++;
        if (r6 !== 7'b0001010) begin
            missCount++;
            $display("[TB] FAIL b2b_first: got r=%b, want 0001010", r6);
        end
        start6 = 1'b1; mode6 = 1'b0; x6 = 6'b000000;
        @(posedge clk);
        #1 start6 = 1'b0;
        vecCount++;
        if (busy6 !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL b2b_accept: got busy=%b after start in done cycle, want 1", busy6);
        end
        waitDone(1'b0, cyc, bcnt);
        vecCount++;
        if (cyc !== 6 || r6 !== 7'b1000000 || ovf6 !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL b2b_second: got cyc=%0d r=%b ovf=%b, want 6 1000000 0", cyc, r6, ovf6);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc, bcnt, seen;
        @(negedge clk);
        start6 = 1'b1; mode6 = 1'b0; x6 = 6'b010011;
        @(posedge clk);
        #1 start6 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vecCount++;
        if (r6 !== 7'b0 || ovf6 !== 1'b0 || busy6 !== 1'b0 || done6 !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL reset_mid_run: got r=%b ovf=%b busy=%b done=%b, want all 0", r6, ovf6, busy6, done6);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done6 || busy6) seen++;
        end
        vecCount++;
        if (seen !== 0) begin
            missCount++;
            $display("[TB] FAIL reset_discard: got %0d busy/done cycles after reset, want 0", seen);
        end
        applyStimulus(1'b0, 1'b1, 8'b00_010011, cyc, bcnt);
        vecCount++;
        if (cyc !== 6 || r6 !== 7'b0010011 || ovf6 !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL after_reset: got cyc=%0d r=%b ovf=%b, want 6 0010011 0", cyc, r6, ovf6);
        end
    endtask

    task automatic test_width8();
        int cyc, bcnt;
        applyStimulus(1'b1, 1'b0, 8'h80, cyc, bcnt);
        vecCount++;
        if (r8 !== EXP_MIN8 || ovf8 !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL w8_neg_min: got r=%b ovf=%b, want %b 1", r8, ovf8, EXP_MIN8);
        end
        applyStimulus(1'b1, 1'b0, 8'h01, cyc, bcnt);
        vecCount++;
        if (r8 !== 9'b0_1111_1111 || ovf8 !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL w8_neg_one: got r=%b ovf=%b, want 011111111 0", r8, ovf8);
        end
        vecCount++;
        if (cyc !== 8 || bcnt !== 8) begin
            missCount++;
            $display("[TB] FAIL w8_latency: got done at %0d busy %0d cycles, want 8/8", cyc, bcnt);
        end
    endtask

    initial begin
        test_reset();
        test_negate();
        test_abs();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_width8();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
